// File: rtl/pipe_lsu.sv
// pipe_lsu: MEM-stage load/store unit with a single-beat bus master.
// Handles alignment, lane steering, load extension and bus timeouts.
`timescale 1ns/1ps

module pipe_lsu #(
  parameter int unsigned P_TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_lsu_valid,
  input  logic        i_lsu_we,
  input  logic [3:0]  i_lsu_byte_sel,
  input  logic [2:0]  i_lsu_funct3,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_lsu_wdata,
  output logic        o_lsu_stall,
  output logic        o_lsu_done,
  output logic [31:0] o_lsu_rdata,
  output logic        o_lsu_misalign,
  output logic        o_lsu_buserr,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_gnt,
  input  logic        i_bus_rvalid,
  input  logic [31:0] i_bus_rdata
);

  localparam int unsigned CW =
    (P_TIMEOUT < 2) ? 1 : $clog2(P_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_DONE
  } state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [29:0] wa;
    logic [1:0]  off;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

  state_t        state;
  logic [CW-1:0] cnt;
  txn_t          txn_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic          misaligned;
  logic          launch;
  logic          wait_last;
  logic          mis_now;
  logic [31:0]   rshift;
  logic [31:0]   rext;

  // Alignment check on the incoming request size
  always_comb begin
    misaligned = 1'b0;
    unique case (1'b1)
      (i_lsu_byte_sel == 4'b1111):
        misaligned = (i_lsu_addr[1:0] != 2'b00);
      (i_lsu_byte_sel == 4'b0011):
        misaligned = i_lsu_addr[0];
      default:
        misaligned = 1'b0;
    endcase
  end

  assign launch    = i_lsu_valid & ~misaligned;
  // Once granted on the final wait cycle, RESP still gets one cycle.
  assign wait_last = (cnt >= CW'(P_TIMEOUT - 1));

  // Lane select and sign/zero extension of the returned word
  always_comb begin
    rshift = i_bus_rdata >> {txn_q.off, 3'b000};
    rext   = rshift;
    case (txn_q.f3)
      3'b000:  rext = {{24{rshift[7]}}, rshift[7:0]};
      3'b001:  rext = {{16{rshift[15]}}, rshift[15:0]};
      3'b100:  rext = {24'd0, rshift[7:0]};
      3'b101:  rext = {16'd0, rshift[15:0]};
      default: rext = rshift;
    endcase
  end

  // Transaction FSM with wait counter and load result register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      txn_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          err_q <= 1'b0;
          if (launch) begin
            txn_q.we    <= i_lsu_we;
            txn_q.f3    <= i_lsu_funct3;
            txn_q.wa    <= i_lsu_addr[31:2];
            txn_q.off   <= i_lsu_addr[1:0];
            txn_q.be    <= i_lsu_byte_sel << i_lsu_addr[1:0];
            txn_q.wdata <= i_lsu_wdata << {i_lsu_addr[1:0], 3'b000};
            cnt         <= '0;
            state       <= S_REQ;
          end
        end
        S_REQ: begin
          if (i_bus_gnt) begin
            cnt   <= cnt + 1'b1;
            state <= txn_q.we ? S_DONE : S_RESP;
          end else if (wait_last) begin
            err_q <= 1'b1;
            if (!txn_q.we) rdata_q <= '0;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (i_bus_rvalid) begin
            rdata_q <= rext;
            state   <= S_DONE;
          end else if (wait_last) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
            state   <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign mis_now = i_rstn & i_lsu_valid & misaligned &
                   (state == S_IDLE);

  assign o_lsu_misalign = mis_now;
  assign o_lsu_done     = (state == S_DONE) | mis_now;
  assign o_lsu_buserr   = err_q & (state == S_DONE);
  assign o_lsu_stall    = i_rstn & (
                            ((state == S_IDLE) & launch) |
                            (state == S_REQ) |
                            (state == S_RESP));
  assign o_lsu_rdata    = rdata_q;

  assign o_bus_req   = (state == S_REQ);
  assign o_bus_we    = txn_q.we;
  assign o_bus_addr  = {txn_q.wa, 2'b00};
  assign o_bus_be    = txn_q.be;
  assign o_bus_wdata = txn_q.wdata;

endmodule

// File: tb/tb_pipe_lsu.sv
// tb_pipe_lsu: directed table plus random transactions for pipe_lsu.
// Expected results come from a transaction-level model of the LSU rules.
`timescale 1ns/1ps

module tb_pipe_lsu;

  localparam int unsigned W = 4;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic        i_lsu_valid = 1'b0;
  logic        i_lsu_we = 1'b0;
  logic [3:0]  i_lsu_byte_sel = 4'h0;
  logic [2:0]  i_lsu_funct3 = 3'h0;
  logic [31:0] i_lsu_addr = '0;
  logic [31:0] i_lsu_wdata = '0;
  logic        o_lsu_stall;
  logic        o_lsu_done;
  logic [31:0] o_lsu_rdata;
  logic        o_lsu_misalign;
  logic        o_lsu_buserr;
  logic        o_bus_req;
  logic        o_bus_we;
  logic [31:0] o_bus_addr;
  logic [3:0]  o_bus_be;
  logic [31:0] o_bus_wdata;
  logic        i_bus_gnt = 1'b0;
  logic        i_bus_rvalid = 1'b0;
  logic [31:0] i_bus_rdata = '0;

  always #5 i_clk = ~i_clk;

  pipe_lsu #(.P_TIMEOUT(W)) dut (
    .i_clk         (i_clk),
    .i_rstn        (i_rstn),
    .i_lsu_valid   (i_lsu_valid),
    .i_lsu_we      (i_lsu_we),
    .i_lsu_byte_sel(i_lsu_byte_sel),
    .i_lsu_funct3  (i_lsu_funct3),
    .i_lsu_addr    (i_lsu_addr),
    .i_lsu_wdata   (i_lsu_wdata),
    .o_lsu_stall   (o_lsu_stall),
    .o_lsu_done    (o_lsu_done),
    .o_lsu_rdata   (o_lsu_rdata),
    .o_lsu_misalign(o_lsu_misalign),
    .o_lsu_buserr  (o_lsu_buserr),
    .o_bus_req     (o_bus_req),
    .o_bus_we      (o_bus_we),
    .o_bus_addr    (o_bus_addr),
    .o_bus_be      (o_bus_be),
    .o_bus_wdata   (o_bus_wdata),
    .i_bus_gnt     (i_bus_gnt),
    .i_bus_rvalid  (i_bus_rvalid),
    .i_bus_rdata   (i_bus_rdata)
  );

  // gd: REQ cycles before gnt; rd: RESP cycles before rvalid;
  // rvg: extra rvalid in the gnt cycle (must be ignored).
  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rword;
    int          gd;
    int          rd;
    logic        rvg;
    int          e_done;
    logic        e_err;
    logic        e_mis;
    int          e_req;
    logic [3:0]  e_be;
    logic [31:0] e_baddr;
    logic [31:0] e_bwdata;
    logic [31:0] e_rdata;
  } vec_t;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] m_rdata = '0;
  vec_t        tbl[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(
    logic we, logic [3:0] sel, logic [2:0] f3,
    logic [31:0] addr, logic [31:0] wdata,
    logic [31:0] rword, int gd, int rd, logic rvg,
    int e_done, logic e_err, logic e_mis, int e_req,
    logic [3:0] e_be, logic [31:0] e_baddr,
    logic [31:0] e_bwdata, logic [31:0] e_rdata);
    vec_t v;
    v.we = we; v.sel = sel; v.f3 = f3;
    v.addr = addr; v.wdata = wdata; v.rword = rword;
    v.gd = gd; v.rd = rd; v.rvg = rvg;
    v.e_done = e_done; v.e_err = e_err; v.e_mis = e_mis;
    v.e_req = e_req; v.e_be = e_be; v.e_baddr = e_baddr;
    v.e_bwdata = e_bwdata; v.e_rdata = e_rdata;
    return v;
  endfunction

  // Load result from the word the bus returned
  function automatic logic [31:0] ext(
    logic [2:0] f3, logic [31:0] a, logic [31:0] word);
    logic [31:0] w;
    logic [31:0] r;
    w = word / (32'd1 << (8 * (a % 4)));
    case (f3)
      3'b000: begin
        r = w % 256;
        if (r >= 128) r = r - 256;
      end
      3'b001: begin
        r = w % 65536;
        if (r >= 32768) r = r - 65536;
      end
      3'b100: r = w % 256;
      3'b101: r = w % 65536;
      default: r = w;
    endcase
    return r;
  endfunction

  // Transaction-level outcome: cycle of done counted from the valid cycle
  function automatic vec_t model(vec_t v);
    vec_t r;
    int   off;
    int   t_last;
    int   r_at;
    logic [7:0] be8;
    logic mis;
    r = v;
    off = int'(v.addr % 4);
    mis = (v.sel == 4'hF && off != 0) ||
          (v.sel == 4'h3 && (off % 2) == 1);
    be8 = 8'(v.sel) * 8'(1 << off);
    r.e_be = be8[3:0];
    r.e_baddr = v.addr - (v.addr % 4);
    r.e_bwdata = v.wdata * (32'd1 << (8 * off));
    r.e_err = 1'b0;
    r.e_mis = 1'b0;
    r.e_rdata = m_rdata;
    if (mis) begin
      r.e_mis = 1'b1;
      r.e_done = 0;
      r.e_req = 0;
    end else if (v.gd >= int'(W)) begin
      r.e_done = 1 + int'(W);
      r.e_err = 1'b1;
      r.e_req = int'(W);
      if (!v.we) r.e_rdata = '0;
    end else begin
      r.e_req = v.gd + 1;
      if (v.we) begin
        r.e_done = 2 + v.gd;
      end else begin
        t_last = (int'(W) - 1 > v.gd + 1) ?
                 int'(W) - 1 : v.gd + 1;
        r_at = v.gd + 1 + v.rd;
        if (r_at <= t_last) begin
          r.e_done = r_at + 2;
          r.e_rdata = ext(v.f3, v.addr, v.rword);
        end else begin
          r.e_done = t_last + 2;
          r.e_err = 1'b1;
          r.e_rdata = '0;
        end
      end
    end
    return r;
  endfunction

  task automatic run_txn(input string tag, input vec_t v);
    int   stall_n = 0;
    int   done_n = 0;
    int   done_c = -1;
    int   req_n = 0;
    logic err_seen = 1'b0;
    logic mis_seen = 1'b0;
    logic stray = 1'b0;
    logic bad = 1'b0;
    int   gc = 1 + v.gd;
    int   rc = 2 + v.gd + v.rd;
    for (int c = 0; c <= v.e_done + 2; c++) begin
      @(negedge i_clk);
      i_lsu_valid    = (c <= v.e_done);
      i_lsu_we       = v.we;
      i_lsu_byte_sel = v.sel;
      i_lsu_funct3   = v.f3;
      i_lsu_addr     = v.addr;
      i_lsu_wdata    = v.wdata;
      i_bus_gnt      = (c == gc);
      i_bus_rvalid   = (c == rc) || (v.rvg && c == gc);
      i_bus_rdata    = v.rword;
      #1;
      if (o_lsu_stall) stall_n++;
      if (o_lsu_done) begin
        done_n++;
        done_c = c;
        if (o_lsu_buserr) err_seen = 1'b1;
        if (o_lsu_misalign) mis_seen = 1'b1;
      end else if (o_lsu_buserr || o_lsu_misalign) begin
        stray = 1'b1;
      end
      if (o_bus_req) begin
        req_n++;
        if (o_bus_addr !== v.e_baddr ||
            o_bus_be !== v.e_be ||
            o_bus_wdata !== v.e_bwdata ||
            o_bus_we !== v.we)
          bad = 1'b1;
      end
    end
    i_lsu_valid  = 1'b0;
    i_bus_gnt    = 1'b0;
    i_bus_rvalid = 1'b0;
    chk({tag, ".done_n"}, done_n, 1);
    chk({tag, ".done_c"}, done_c, v.e_done);
    chk({tag, ".stall"}, stall_n, v.e_done);
    chk({tag, ".req_n"}, req_n, v.e_req);
    chk({tag, ".buserr"}, err_seen, v.e_err);
    chk({tag, ".misalign"}, mis_seen, v.e_mis);
    chk({tag, ".stray"}, stray, 0);
    chk({tag, ".rdata"}, o_lsu_rdata, v.e_rdata);
    if (v.e_req > 0) chk({tag, ".busfields"}, bad, 0);
    m_rdata = v.e_rdata;
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    int   sz;
    v = '0;
    sz = $urandom_range(0, 2);
    v.we = 1'($urandom_range(0, 1));
    v.addr = $urandom;
    if ($urandom_range(0, 3) != 0)
      v.addr = v.addr - (v.addr % (32'd1 << sz));
    v.wdata = $urandom;
    v.rword = $urandom;
    v.gd = $urandom_range(0, 5);
    v.rd = $urandom_range(0, 4);
    v.rvg = 1'($urandom_range(0, 1));
    case (sz)
      0: begin
        v.sel = 4'b0001;
        v.f3 = v.we ? 3'b000 :
               ($urandom_range(0, 1) ? 3'b100 : 3'b000);
      end
      1: begin
        v.sel = 4'b0011;
        v.f3 = v.we ? 3'b001 :
               ($urandom_range(0, 1) ? 3'b101 : 3'b001);
      end
      default: begin
        v.sel = 4'b1111;
        case ($urandom_range(0, 3))
          0: v.f3 = 3'b011;
          1: v.f3 = 3'b110;
          2: v.f3 = 3'b111;
          default: v.f3 = 3'b010;
        endcase
        if (v.we) v.f3 = 3'b010;
      end
    endcase
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic quiet;
    vec_t rv;

    // we sel f3 addr wdata rword gd rd rvg
    // done err mis req be baddr bwdata rdata
    tbl.push_back(mkv(0, 4'b0001, 3'b000, 32'h1003, 0,
      32'h80FF_0000, 1, 0, 0,
      4, 0, 0, 2, 4'b1000, 32'h1000, 0, 32'hFFFF_FF80));
    tbl.push_back(mkv(1, 4'b0011, 3'b001, 32'h2002, 32'hABCD,
      0, 0, 0, 0,
      2, 0, 0, 1, 4'b1100, 32'h2000, 32'hABCD_0000,
      32'hFFFF_FF80));
    tbl.push_back(mkv(0, 4'b1111, 3'b010, 32'h3001, 0,
      0, 0, 0, 0,
      0, 0, 1, 0, 4'b0000, 0, 0, 32'hFFFF_FF80));
    tbl.push_back(mkv(0, 4'b0011, 3'b101, 32'h4002, 0,
      32'h1234_5678, 0, 10, 0,
      5, 1, 0, 1, 4'b1100, 32'h4000, 0, 0));
    tbl.push_back(mkv(0, 4'b0011, 3'b001, 32'h0006, 0,
      32'h8001_1234, 0, 1, 1,
      4, 0, 0, 1, 4'b1100, 32'h0004, 0, 32'hFFFF_8001));
    tbl.push_back(mkv(0, 4'b0001, 3'b100, 32'h5001, 0,
      32'h0000_9A00, 0, 0, 0,
      3, 0, 0, 1, 4'b0010, 32'h5000, 0, 32'h0000_009A));
    tbl.push_back(mkv(1, 4'b0001, 3'b000, 32'h6003, 32'h77,
      0, 3, 0, 0,
      5, 0, 0, 4, 4'b1000, 32'h6000, 32'h7700_0000,
      32'h0000_009A));
    tbl.push_back(mkv(1, 4'b1111, 3'b010, 32'h7000,
      32'hDEAD_BEEF, 0, 5, 0, 0,
      5, 1, 0, 4, 4'b1111, 32'h7000, 32'hDEAD_BEEF,
      32'h0000_009A));
    tbl.push_back(mkv(0, 4'b1111, 3'b010, 32'h8000, 0,
      32'hCAFE_F00D, 0, 2, 0,
      5, 0, 0, 1, 4'b1111, 32'h8000, 0, 32'hCAFE_F00D));
    tbl.push_back(mkv(0, 4'b1111, 3'b010, 32'h8004, 0,
      32'h1111_2222, 0, 3, 0,
      5, 1, 0, 1, 4'b1111, 32'h8004, 0, 0));
    tbl.push_back(mkv(0, 4'b0011, 3'b001, 32'hA000, 0,
      32'h0000_7FFE, 3, 0, 0,
      6, 0, 0, 4, 4'b0011, 32'hA000, 0, 32'h0000_7FFE));

    // Reset state, with an aligned request pending on the inputs
    i_lsu_valid = 1'b1;
    i_lsu_byte_sel = 4'hF;
    i_lsu_addr = 32'h0;
    #2;
    chk("rst.stall", o_lsu_stall, 0);
    chk("rst.done", o_lsu_done, 0);
    chk("rst.req", o_bus_req, 0);
    chk("rst.rdata", o_lsu_rdata, 0);
    chk("rst.baddr", o_bus_addr, 0);
    i_lsu_addr = 32'h1;
    #1;
    chk("rst.misalign", o_lsu_misalign, 0);
    i_lsu_valid = 1'b0;
    @(negedge i_clk);
    i_rstn = 1'b1;

    foreach (tbl[i])
      run_txn($sformatf("vec%0d", i), tbl[i]);

    // Reset asserted while a load waits in RESP
    @(negedge i_clk);
    i_lsu_valid = 1'b1;
    i_lsu_we = 1'b0;
    i_lsu_byte_sel = 4'hF;
    i_lsu_funct3 = 3'b010;
    i_lsu_addr = 32'h9000;
    @(negedge i_clk);
    i_bus_gnt = 1'b1;
    @(negedge i_clk);
    i_bus_gnt = 1'b0;
    #1;
    chk("rstmid.stall_before", o_lsu_stall, 1);
    i_rstn = 1'b0;
    #1;
    chk("rstmid.stall", o_lsu_stall, 0);
    chk("rstmid.req", o_bus_req, 0);
    chk("rstmid.rdata", o_lsu_rdata, 0);
    chk("rstmid.baddr", o_bus_addr, 0);
    i_lsu_valid = 1'b0;
    @(negedge i_clk);
    i_rstn = 1'b1;
    quiet = 1'b1;
    for (int c = 0; c < 4; c++) begin
      i_bus_rvalid = (c < 2);
      i_bus_rdata = 32'h5555_AAAA;
      #1;
      if (o_lsu_done || o_lsu_stall || o_bus_req)
        quiet = 1'b0;
      @(negedge i_clk);
    end
    i_bus_rvalid = 1'b0;
    chk("rstmid.quiet", quiet, 1);
    chk("rstmid.rdata_after", o_lsu_rdata, 0);
    m_rdata = '0;

    for (int i = 0; i < 40; i++) begin
      rv = model(rand_vec());
      run_txn($sformatf("rnd%0d", i), rv);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_lsu.md
PIPE_LSU -- requirements
Module: pipe_lsu

Interface
REQ-001 Parameter P_TIMEOUT, default 255, bus-wait cycles before a transaction aborts with error.
REQ-002 i_clk  input  1  sole clock; all state on rising edge.
REQ-003 i_rstn  input  1  reset; asynchronous, active-low.
REQ-004 i_lsu_valid  input  1  MEM-stage instruction is a load or store.
REQ-005 i_lsu_we  input  1  1 = store (MemWrite), 0 = load.
REQ-006 i_lsu_byte_sel  input  4  unshifted lane mask: 0001 byte, 0011 half, 1111 word.
REQ-007 i_lsu_funct3  input  3  RV32I load/store funct3 (selects sign/zero extension).
REQ-008 i_lsu_addr  input  32  byte address (ALU result).
REQ-009 i_lsu_wdata  input  32  store data, LSB-aligned.
REQ-010 o_lsu_stall  output  1  freeze pipeline stages up to and including MEM.
REQ-011 o_lsu_done  output  1  one-cycle pulse, access finished.
REQ-012 o_lsu_rdata  output  32  extended load result, registered.
REQ-013 o_lsu_misalign  output  1  one-cycle flag, misaligned access rejected.
REQ-014 o_lsu_buserr  output  1  one-cycle flag with o_lsu_done, timeout abort.
REQ-015 o_bus_req, o_bus_we  output  1 each  bus request and direction.
REQ-016 o_bus_addr  output  32  word address {addr[31:2],2'b00}.
REQ-017 o_bus_be  output  4  lane enables = byte_sel << addr[1:0].
REQ-018 o_bus_wdata  output  32  wdata << (8*addr[1:0]).
REQ-019 i_bus_gnt, i_bus_rvalid  input  1 each  request accepted; read data valid.
REQ-020 i_bus_rdata  input  32  read word.

Function
REQ-021 FSM states SHALL be IDLE, REQ, RESP, DONE.
REQ-022 Misaligned: half with addr[0]=1, or word with addr[1:0]!=0; byte never misaligned.
REQ-023 IDLE, valid, aligned: latch addr/we/be/wdata/funct3, go REQ.
REQ-024 IDLE, valid, misaligned: no bus request, o_lsu_misalign=1 and o_lsu_done=1 same cycle combinationally, stall=0, stay IDLE.
REQ-025 REQ: o_bus_req=1 with latched fields held stable until i_bus_gnt; on gnt store -> DONE, load -> RESP.
REQ-026 RESP: on i_bus_rvalid capture extracted data into o_lsu_rdata, go DONE; i_bus_rvalid ignored in all other states.
REQ-027 DONE: o_lsu_done=1 one cycle, stall=0, unconditionally to IDLE (no relaunch in DONE even if valid still high).
REQ-028 o_lsu_stall = (IDLE & valid & aligned) | REQ | RESP.
REQ-029 Extraction: w = rdata >> 8*addr[1:0]; LB sign-extend w[7], LBU zero-extend w[7:0], LH sign-extend w[15], LHU zero-extend w[15:0], LW w; other funct3 treated as LW.
REQ-030 o_lsu_rdata SHALL hold its value until the next successful load capture; stores do not alter it.
REQ-031 Wait counter clears on entry to REQ, increments each REQ/RESP cycle; reaching P_TIMEOUT -> DONE with o_lsu_buserr=1, o_bus_req dropped, o_lsu_rdata set to 0 for loads.
REQ-032 i_bus_gnt and i_bus_rvalid asserted same cycle in REQ: gnt taken, rvalid ignored; load waits in RESP.

Reset
REQ-033 i_rstn low SHALL immediately force IDLE, counter 0, o_lsu_rdata 0, all outputs 0, regardless of clock.
REQ-034 Reset mid-transaction abandons it; no done pulse after release.

Verification
REQ-035 LB addr 0x1003, bus rdata 0x80FF_0000, gnt after 2 cycles, rvalid 1 cycle later -> o_bus_be 1000, o_lsu_rdata 0xFFFF_FF80, stall for 4 cycles, single done.
REQ-036 SH addr 0x2002, wdata 0x0000_ABCD, gnt immediate -> o_bus_addr 0x2000, be 1100, bus wdata 0xABCD_0000, done 2 cycles after valid.
REQ-037 LW addr 0x3001 -> no o_bus_req, misalign=1 and done=1 same cycle, stall 0.
REQ-038 LHU addr 0x4002, gnt but no rvalid, P_TIMEOUT=4 -> buserr with done after 4 wait cycles, rdata 0.
REQ-039 i_rstn low during RESP -> outputs 0 asynchronously, IDLE; later rvalid ignored, no done.
